pll_sync_xfer: RTL and testbench

Fast-clock transfer stage that sits directly downstream of the PLL phase counter. It consumes the fast-domain phase count of the slow clock and uses it to move data across the PLL-related clock boundary at fixed, timing-safe phases.
- Slow → fast: samples slow-domain data at a chosen phase and re-emits it with a one-cycle valid.
- Fast → slow: buffers fast-domain words and launches them so they are held stable for one full slow period.

It also monitors the phase count and reports lock and sync errors.

---
 rtl/fmcw_pkg.sv | 12 +
 rtl/sync_fifo2.sv | 50 +++++
 rtl/pll_sync_xfer.sv | 110 +++++++++++
 tb/tb_pll_sync_xfer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fmcw_pkg.sv
// Helpers shared by the PLL phase counter and the blocks that consume its count.
package fmcw_pkg;

  function automatic int cw_of(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic int next_phase(input int cur, input int ratio);
    return (cur >= ratio - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO with a flush that empties it in one cycle.
module sync_fifo2 #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is left unreset; nothing reads it while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pll_sync_xfer.sv
// Moves data between the PLL slow clock and fst_clk at fixed phases of the
// fast-domain phase count, and tracks lock of that count.
module pll_sync_xfer
  import fmcw_pkg::*;
#(
  parameter  int RATIO         = 8,
  parameter  int DATA_WIDTH    = 12,
  parameter  int CAPTURE_PHASE = 4,
  parameter  int LAUNCH_PHASE  = 0,
  localparam int CW            = cw_of(RATIO)
) (
  input  logic                  fst_clk,
  input  logic                  rst,
  input  logic [CW-1:0]         ctr,
  input  logic [DATA_WIDTH-1:0] slw_din,
  output logic [DATA_WIDTH-1:0] fst_dout,
  output logic                  fst_dout_valid,
  input  logic [DATA_WIDTH-1:0] fst_din,
  input  logic                  fst_din_valid,
  output logic                  fst_din_ready,
  output logic [DATA_WIDTH-1:0] slw_dout,
  output logic                  slw_dout_valid,
  output logic                  locked,
  output logic                  sync_err
);

  localparam int          LW       = $clog2(2 * RATIO + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(2 * RATIO);
  localparam logic [CW-1:0] CAP_PH   = CW'(CAPTURE_PHASE);
  localparam logic [CW-1:0] LAUNCH_PH = CW'(LAUNCH_PHASE);

  logic [CW-1:0]         ctr_q;
  logic [CW-1:0]         exp_phase;
  logic                  first;
  logic [LW-1:0]         lock_cnt;
  logic [LW-1:0]         lock_cnt_nxt;
  logic                  mismatch;
  logic                  active;
  logic                  at_cap;
  logic                  at_launch;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;

  assign exp_phase = CW'(next_phase(int'(ctr_q), RATIO));
  assign mismatch  = !first && (ctr != exp_phase);
  // A glitching count means the phase is untrustworthy right now, so the
  // discontinuity cycle itself neither captures nor launches.
  assign active    = locked && !mismatch;
  assign at_cap    = (ctr == CAP_PH);
  assign at_launch = (ctr == LAUNCH_PH);

  // Handshake: a word transfers on every edge where fst_din_valid and
  // fst_din_ready are both high; ready never depends on valid.
  assign fst_din_ready = locked && !full;
  assign push          = fst_din_valid && fst_din_ready;
  assign pop           = active && at_launch && !empty;

  always_comb begin
    lock_cnt_nxt = lock_cnt;
    if (mismatch)
      lock_cnt_nxt = '0;
    else if (!first && lock_cnt != LOCK_MAX)
      lock_cnt_nxt = lock_cnt + LW'(1);
  end

  always_ff @(posedge fst_clk) begin
    if (rst) begin
      ctr_q          <= '0;
      first          <= 1'b1;
      lock_cnt       <= '0;
      locked         <= 1'b0;
      sync_err       <= 1'b0;
      fst_dout       <= '0;
      fst_dout_valid <= 1'b0;
      slw_dout       <= '0;
      slw_dout_valid <= 1'b0;
    end else begin
      ctr_q          <= ctr;
      first          <= 1'b0;
      lock_cnt       <= lock_cnt_nxt;
      locked         <= (lock_cnt_nxt == LOCK_MAX);
      sync_err       <= mismatch;
      fst_dout_valid <= active && at_cap;
      if (active && at_cap) fst_dout <= slw_din;
      // slw_dout keeps its last word across a loss of lock; only valid drops.
      if (mismatch) begin
        slw_dout_valid <= 1'b0;
      end else if (active && at_launch) begin
        slw_dout_valid <= !empty;
        if (!empty) slw_dout <= head;
      end
    end
  end

  sync_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (fst_clk),
    .rst   (rst),
    .flush (mismatch),
    .push  (push),
    .din   (fst_din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_pll_sync_xfer.sv
// Bench for pll_sync_xfer: directed scenarios plus randomized traffic against
// a cycle-level reference model built on a queue and modular phase arithmetic.
module tb_pll_sync_xfer;

  localparam int RATIO  = 8;
  localparam int DW     = 12;
  localparam int CAP    = 4;
  localparam int LAUNCH = 0;
  localparam int CW     = $clog2(RATIO);

  // clock / reset signals
  logic          fst_clk = 1'b0;
  logic          rst;
  logic [CW-1:0] ctr;
  logic [DW-1:0] slw_din;
  logic [DW-1:0] fst_dout;
  logic          fst_dout_valid;
  logic [DW-1:0] fst_din;
  logic          fst_din_valid;
  logic          fst_din_ready;
  logic [DW-1:0] slw_dout;
  logic          slw_dout_valid;
  logic          locked;
  logic          sync_err;

  always #5 fst_clk = ~fst_clk;

  pll_sync_xfer #(
    .RATIO(RATIO), .DATA_WIDTH(DW), .CAPTURE_PHASE(CAP), .LAUNCH_PHASE(LAUNCH)
  ) dut (
    .fst_clk        (fst_clk),
    .rst            (rst),
    .ctr            (ctr),
    .slw_din        (slw_din),
    .fst_dout       (fst_dout),
    .fst_dout_valid (fst_dout_valid),
    .fst_din        (fst_din),
    .fst_din_valid  (fst_din_valid),
    .fst_din_ready  (fst_din_ready),
    .slw_dout       (slw_dout),
    .slw_dout_valid (slw_dout_valid),
    .locked         (locked),
    .sync_err       (sync_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model state
  int            m_ctr_q;
  bit            m_first;
  int            m_run;
  bit            m_locked;
  bit            m_sync_err;
  logic [DW-1:0] m_dout;
  bit            m_dout_v;
  logic [DW-1:0] m_sdout;
  bit            m_sdout_v;
  logic [DW-1:0] exp_q[$];
  int            phase;
  bit            last_ready;

  task automatic model_reset();
    m_ctr_q    = 0;
    m_first    = 1'b1;
    m_run      = 0;
    m_locked   = 1'b0;
    m_sync_err = 1'b0;
    m_dout     = '0;
    m_dout_v   = 1'b0;
    m_sdout    = '0;
    m_sdout_v  = 1'b0;
    exp_q.delete();
  endtask

  // driver: one fast cycle with the given inputs, model update, then checks
  task automatic step(input bit r, input int c, input logic [DW-1:0] sd,
                      input bit dv, input logic [DW-1:0] d);
    bit exp_ready;
    bit bad;
    bit act;
    bit accept;
    rst           = r;
    ctr           = CW'(c);
    slw_din       = sd;
    fst_din_valid = dv;
    fst_din       = d;
    #1;
    exp_ready  = m_locked && (exp_q.size() < 2);
    last_ready = fst_din_ready;
    check("ready", fst_din_ready, exp_ready);
    if (r) begin
      model_reset();
    end else begin
      accept   = dv && exp_ready;
      bad      = !m_first && (c != (m_ctr_q + 1) % RATIO);
      act      = m_locked && !bad;
      m_dout_v = act && (c == CAP);
      if (m_dout_v) m_dout = sd;
      if (bad) begin
        m_sdout_v = 1'b0;
        exp_q.delete();
      end else if (act && c == LAUNCH) begin
        if (exp_q.size() > 0) begin
          m_sdout   = exp_q.pop_front();
          m_sdout_v = 1'b1;
        end else begin
          m_sdout_v = 1'b0;
        end
      end
      if (accept && !bad) exp_q.push_back(d);
      m_sync_err = bad;
      if (bad) begin
        m_run    = 0;
        m_locked = 1'b0;
      end else if (!m_first) begin
        if (m_run < 2 * RATIO) m_run++;
        m_locked = (m_run == 2 * RATIO);
      end
      m_first = 1'b0;
      m_ctr_q = c;
    end
    @(posedge fst_clk);
    #1;
    check("fst_dout", fst_dout, m_dout);
    check("fst_dout_valid", fst_dout_valid, m_dout_v);
    check("slw_dout", slw_dout, m_sdout);
    check("slw_dout_valid", slw_dout_valid, m_sdout_v);
    check("locked", locked, m_locked);
    check("sync_err", sync_err, m_sync_err);
  endtask

  task automatic tick(input bit dv, input logic [DW-1:0] d);
    step(1'b0, phase, DW'($urandom), dv, d);
    phase = (phase + 1) % RATIO;
  endtask

  task automatic run_to_launch();
    for (int k = 0; k < RATIO && phase != LAUNCH; k++) tick(1'b0, '0);
    tick(1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1; ctr = '0; slw_din = '0; fst_din = '0; fst_din_valid = 1'b0;
    repeat (3) step(1'b1, 0, '0, 1'b0, '0);
    check("reset_outputs", {fst_dout, fst_dout_valid, slw_dout, slw_dout_valid,
                            locked, sync_err, fst_din_ready}, 32'd0);

    // lock acquisition with a clean count
    phase = 0;
    for (int i = 1; i <= 17; i++) begin
      tick(1'b0, '0);
      if (i == 16) check("lock_early", locked, 1'b0);
      if (i == 17) check("lock_at_17", locked, 1'b1);
      check("no_sync_err", sync_err, 1'b0);
    end

    // capture path
    for (int k = 0; k < RATIO && phase != CAP; k++) tick(1'b0, '0);
    step(1'b0, phase, 12'hA5C, 1'b0, '0);
    phase = (phase + 1) % RATIO;
    check("cap_data", fst_dout, 12'hA5C);
    check("cap_valid", fst_dout_valid, 1'b1);
    tick(1'b0, '0);
    check("cap_strobe_once", fst_dout_valid, 1'b0);
    check("cap_hold", fst_dout, 12'hA5C);

    // launch with backpressure: phase is 6 here
    tick(1'b1, 12'h001);
    check("bp_accept1", last_ready, 1'b1);
    tick(1'b1, 12'h002);
    check("bp_accept2", last_ready, 1'b1);
    tick(1'b1, 12'h003);
    check("bp_ready_low", last_ready, 1'b0);
    check("launch_001", slw_dout, 12'h001);
    check("launch_001_v", slw_dout_valid, 1'b1);
    tick(1'b1, 12'h003);
    check("bp_accept3", last_ready, 1'b1);
    run_to_launch();
    check("launch_002", slw_dout, 12'h002);
    run_to_launch();
    check("launch_003", slw_dout, 12'h003);
    run_to_launch();
    check("idle_valid", slw_dout_valid, 1'b0);
    check("idle_hold", slw_dout, 12'h003);

    // glitch with one queued word: phase is 1 here
    tick(1'b1, 12'h7E7);
    tick(1'b0, '0);
    tick(1'b0, '0);
    step(1'b0, 6, '0, 1'b0, '0);
    phase = 7;
    check("glitch_sync_err", sync_err, 1'b1);
    check("glitch_unlock", locked, 1'b0);
    check("glitch_ready", fst_din_ready, 1'b0);
    tick(1'b0, '0);
    check("sync_err_pulse", sync_err, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      tick(1'b0, '0);
      if (i == 15) check("relock_early", locked, 1'b0);
      if (i == 16) check("relock", locked, 1'b1);
    end
    run_to_launch();
    check("flushed_valid", slw_dout_valid, 1'b0);
    check("flushed_hold", slw_dout, 12'h003);

    // reset with a full FIFO
    for (int k = 0; k < RATIO && phase != 1; k++) tick(1'b0, '0);
    tick(1'b1, 12'h111);
    tick(1'b1, 12'h222);
    step(1'b1, phase, '0, 1'b0, '0);
    check("midrst_outputs", {fst_dout, fst_dout_valid, slw_dout, slw_dout_valid,
                             locked, sync_err, fst_din_ready}, 32'd0);
    phase = 0;

    // randomized traffic with occasional glitches and resets
    for (int i = 0; i < 700; i++) begin
      int sel;
      int c;
      sel = $urandom_range(0, 199);
      if (sel < 4) begin
        c = $urandom_range(0, RATIO - 1);
        step(1'b0, c, DW'($urandom), ($urandom_range(0, 2) == 0), DW'($urandom));
        phase = (c + 1) % RATIO;
      end else if (sel == 4) begin
        step(1'b1, phase, '0, 1'b0, '0);
        phase = (phase + 1) % RATIO;
      end else begin
        tick(($urandom_range(0, 2) == 0), DW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
